// File: rtl/a0_trace_fifo_if.sv
// Bus between the a0 trace FIFO and its environment: capture side (a0/en) and
// the show-ahead valid/ready drain side plus status.
interface a0_trace_fifo_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] a0_i;
  logic          en_i;
  logic          out_ready_i;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic [AW:0]   count_o;
  logic          overflow_o;

  modport slave (
    input  a0_i, en_i, out_ready_i,
    output out_valid_o, out_data_o, count_o, overflow_o
  );

  modport master (
    output a0_i, en_i, out_ready_i,
    input  out_valid_o, out_data_o, count_o, overflow_o
  );
endinterface

// File: rtl/a0_trace_fifo.sv
// Records every change of the CPU a0 register while enabled into a show-ahead
// FIFO; captures arriving on a full FIFO are dropped and flagged stickily.
module a0_trace_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  a0_trace_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] last_q, last_d;
  logic          primed_q, primed_d;

  logic req, pop, push, full, drop;

  // last_q tracks the most recent requested value even when the entry is dropped,
  // so a full FIFO does not cause the same value to be re-requested every cycle.
  always_comb begin
    req  = bus.en_i & (!primed_q | (bus.a0_i != last_q));
    pop  = (count_q != '0) & bus.out_ready_i;
    full = (count_q == FULL_C);
    push = req & (!full | pop);
    drop = req & full & !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    last_d     = last_q;
    primed_d   = primed_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) overflow_d = 1'b1;

    if (req) begin
      last_d   = bus.a0_i;
      primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
      primed_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
      primed_q   <= primed_d;
    end
  end

  // Storage is intentionally not cleared on reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.a0_i;
  end

  assign bus.out_valid_o = (count_q != '0);
  assign bus.out_data_o  = mem_q[rd_ptr_q];
  assign bus.count_o     = count_q;
  assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed self-checking bench for a0_trace_fifo with hand-computed expectations.
module tb_a0_trace_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   errorCount;
  int   checkCount;

  a0_trace_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  a0_trace_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic en, input logic [DW-1:0] a0, input logic rdy);
    rst             = r;
    bus.en_i        = en;
    bus.a0_i        = a0;
    bus.out_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst = 1'b1;
    bus.en_i = 1'b0;
    bus.a0_i = '0;
    bus.out_ready_i = 1'b0;
    #2;

    // Test 1: reset state, then a0 held at 0 captures exactly once.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("rst_count", 64'(bus.count_o), 64'd0);
    checkOutput("rst_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("rst_overflow", 64'(bus.overflow_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'd0, 1'b0);
    checkOutput("t1_valid_after_first", 64'(bus.out_valid_o), 64'd1);
    checkOutput("t1_count_after_first", 64'(bus.count_o), 64'd1);
    applyStimulus(1'b0, 1'b1, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd0, 1'b0);
    checkOutput("t1_count", 64'(bus.count_o), 64'd1);
    checkOutput("t1_data", 64'(bus.out_data_o), 64'd0);

    // Test 2: 5,5,7,7,9 with ready=1; the 0 drains on the first edge.
    applyStimulus(1'b0, 1'b1, 32'd5, 1'b1);
    checkOutput("t2_data5", 64'(bus.out_data_o), 64'd5);
    checkOutput("t2_count5", 64'(bus.count_o), 64'd1);
    applyStimulus(1'b0, 1'b1, 32'd5, 1'b1);
    checkOutput("t2_empty_after5", 64'(bus.count_o), 64'd0);
    checkOutput("t2_valid_after5", 64'(bus.out_valid_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'd7, 1'b1);
    checkOutput("t2_data7", 64'(bus.out_data_o), 64'd7);
    checkOutput("t2_count7", 64'(bus.count_o), 64'd1);
    applyStimulus(1'b0, 1'b1, 32'd7, 1'b1);
    checkOutput("t2_empty_after7", 64'(bus.count_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'd9, 1'b1);
    checkOutput("t2_data9", 64'(bus.out_data_o), 64'd9);
    checkOutput("t2_count9", 64'(bus.count_o), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'd9, 1'b1);
    checkOutput("t2_drained", 64'(bus.count_o), 64'd0);

    // Test 3: 17 distinct values with ready=0 overflow a 16-entry FIFO.
    for (int i = 1; i <= 16; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
    checkOutput("t3_count_full", 64'(bus.count_o), 64'd16);
    checkOutput("t3_no_overflow_yet", 64'(bus.overflow_o), 64'd0);
    checkOutput("t3_head_stable", 64'(bus.out_data_o), 64'd1);
    applyStimulus(1'b0, 1'b1, 32'd17, 1'b0);
    checkOutput("t3_count_after_drop", 64'(bus.count_o), 64'd16);
    checkOutput("t3_overflow", 64'(bus.overflow_o), 64'd1);
    for (int i = 1; i <= 16; i++) begin
      checkOutput($sformatf("t3_valid_%0d", i), 64'(bus.out_valid_o), 64'd1);
      checkOutput($sformatf("t3_data_%0d", i), 64'(bus.out_data_o), 64'(i));
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    end
    checkOutput("t3_valid_end", 64'(bus.out_valid_o), 64'd0);
    checkOutput("t3_count_end", 64'(bus.count_o), 64'd0);
    checkOutput("t3_overflow_sticky", 64'(bus.overflow_o), 64'd1);

    // Test 4: full FIFO with simultaneous capture and pop.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, DW'(100 + i), 1'b0);
    checkOutput("t4_count_full", 64'(bus.count_o), 64'd16);
    applyStimulus(1'b0, 1'b1, 32'd200, 1'b1);
    checkOutput("t4_count_stays", 64'(bus.count_o), 64'd16);
    checkOutput("t4_no_overflow", 64'(bus.overflow_o), 64'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t4_data_%0d", i), 64'(bus.out_data_o), (i == 15) ? 64'd200 : 64'(101 + i));
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    end
    checkOutput("t4_count_end", 64'(bus.count_o), 64'd0);

    // Test 5: toggling while disabled neither captures nor moves last_q (200).
    applyStimulus(1'b0, 1'b0, 32'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd3, 1'b0);
    checkOutput("t5_disabled_count", 64'(bus.count_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'd3, 1'b0);
    checkOutput("t5_count", 64'(bus.count_o), 64'd1);
    checkOutput("t5_data", 64'(bus.out_data_o), 64'd3);
    applyStimulus(1'b0, 1'b1, 32'd3, 1'b1);
    checkOutput("t5_no_repeat", 64'(bus.count_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd9, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd3, 1'b0);
    checkOutput("t5_same_after_disabled", 64'(bus.count_o), 64'd0);

    // Test 6: reset with 4 entries queued and overflow set; reset overrides capture.
    for (int i = 1; i <= 17; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("t6_count_pre", 64'(bus.count_o), 64'd4);
    checkOutput("t6_overflow_pre", 64'(bus.overflow_o), 64'd1);
    checkOutput("t6_head_pre", 64'(bus.out_data_o), 64'd13);
    applyStimulus(1'b1, 1'b1, 32'd77, 1'b1);
    checkOutput("t6_count_rst", 64'(bus.count_o), 64'd0);
    checkOutput("t6_valid_rst", 64'(bus.out_valid_o), 64'd0);
    checkOutput("t6_overflow_rst", 64'(bus.overflow_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'd4, 1'b0);
    checkOutput("t6_count_post", 64'(bus.count_o), 64'd1);
    checkOutput("t6_data_post", 64'(bus.out_data_o), 64'd4);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
